multicycle_control_unit: RTL

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/cpu_ctrl_pkg.sv | 78 +++++++
 rtl/multicycle_control_unit_if.sv | 41 ++++
 rtl/busy_timer.sv | 27 ++
 rtl/multicycle_control_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle control unit.
//   state_e      : controller FSM states (IDLE, EXEC, MEM, WB)
//   OP_*         : instruction opcode values
//   ALU_*        : ALU operation select codes
//   op_class     : groups an opcode into the sequence it runs
//   exec_alu     : ALU select / source / negate driven during EXEC
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  localparam logic [31:0] OP_LOADI = 32'd0;
  localparam logic [31:0] OP_ADD   = 32'd1;
  localparam logic [31:0] OP_MOV   = 32'd2;
  localparam logic [31:0] OP_SUB   = 32'd3;
  localparam logic [31:0] OP_AND   = 32'd4;
  localparam logic [31:0] OP_OR    = 32'd5;
  localparam logic [31:0] OP_J     = 32'd6;
  localparam logic [31:0] OP_BEQ   = 32'd7;
  localparam logic [31:0] OP_LWD   = 32'd8;
  localparam logic [31:0] OP_LWI   = 32'd9;
  localparam logic [31:0] OP_SWD   = 32'd10;
  localparam logic [31:0] OP_SWI   = 32'd11;

  localparam logic [1:0] ALU_FWD = 2'd0;
  localparam logic [1:0] ALU_ADD = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  typedef enum logic [2:0] {
    CLS_LOADI,
    CLS_ALU,
    CLS_JUMP,
    CLS_BEQ,
    CLS_LOAD,
    CLS_STORE,
    CLS_ILLEGAL
  } op_class_e;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alu_src;
    logic       negate;
  } alu_ctrl_t;

  function automatic op_class_e op_class(input logic [31:0] op);
    case (op)
      OP_LOADI:                        return CLS_LOADI;
      OP_ADD, OP_MOV, OP_SUB,
      OP_AND, OP_OR:                   return CLS_ALU;
      OP_J:                            return CLS_JUMP;
      OP_BEQ:                          return CLS_BEQ;
      OP_LWD, OP_LWI:                  return CLS_LOAD;
      OP_SWD, OP_SWI:                  return CLS_STORE;
      default:                         return CLS_ILLEGAL;
    endcase
  endfunction

  // The "d" memory forms take their address from a register (aluSource=1);
  // the "i" forms use the immediate path.
  function automatic alu_ctrl_t exec_alu(input logic [31:0] op);
    case (op)
      OP_MOV:         return '{ALU_FWD, 1'b1, 1'b0};
      OP_ADD:         return '{ALU_ADD, 1'b1, 1'b0};
      OP_SUB:         return '{ALU_ADD, 1'b1, 1'b1};
      OP_AND:         return '{ALU_AND, 1'b1, 1'b0};
      OP_OR:          return '{ALU_OR,  1'b1, 1'b0};
      OP_BEQ:         return '{ALU_ADD, 1'b1, 1'b1};
      OP_LWD, OP_SWD: return '{ALU_FWD, 1'b1, 1'b0};
      default:        return '{ALU_FWD, 1'b0, 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller <-> datapath/sequencer signal bundle.
//   slave  : the control unit (receives instruction/status, drives controls)
//   master : the instruction source / datapath side
// Handshake: an opcode transfers on a rising edge where instr_valid and
// instr_ready are both 1. instr_ready is 1 only while the controller is
// idle; instr_valid in any other cycle is ignored, and opcode only matters
// in the transfer cycle.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 8,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 16
);
  logic                instr_valid;
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                busywait;
  logic                instr_ready;
  logic [ALUOP_W-1:0]  aluop;
  logic                aluSource;
  logic                negate;
  logic                regWriteEnable;
  logic                memRead;
  logic                memWrite;
  logic                pcWrite;
  logic                branchTaken;
  logic                jump;
  logic                error;
  logic [CNT_W-1:0]    retired;

  modport slave (
    input  instr_valid, opcode, zero, busywait,
    output instr_ready, aluop, aluSource, negate, regWriteEnable, memRead,
           memWrite, pcWrite, branchTaken, jump, error, retired
  );

  modport master (
    output instr_valid, opcode, zero, busywait,
    input  instr_ready, aluop, aluSource, negate, regWriteEnable, memRead,
           memWrite, pcWrite, branchTaken, jump, error, retired
  );
endinterface

// File: rtl/busy_timer.sv
// Counts memory stall cycles and flags when the limit is reached.
//   clk, rst   : clock, synchronous active-high reset
//   i_clear    : zero the count (dominates enable)
//   i_enable   : count this cycle
//   o_expired  : count has reached LIMIT; the count then holds
module busy_timer #(
  parameter int LIMIT = 255,
  parameter int W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_expired = (r_count >= W'(LIMIT));
endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU controller: accepts an opcode in IDLE, then sequences
// EXEC -> (MEM) -> (WB) -> IDLE and drives the datapath controls.
//   CLK, RESET    : clock, synchronous active-high reset
//   bus (slave)   : instruction handshake, zero/busywait status, controls,
//                   retired-instruction counter
//   o_dbg_state   : current FSM state
// Controls are decoded from the state register, the latched opcode and the
// stall timer. Two controls also look at a live status input because they
// must act in the same cycle the status is seen: branchTaken follows zero
// in EXEC, and a store's pcWrite rises in the MEM cycle busywait drops.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 8,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  multicycle_control_unit_if.slave bus,
  output state_e                   o_dbg_state
);
  state_e              r_state;
  state_e              w_next_state;
  logic [OPCODE_W-1:0] r_opcode;
  logic [CNT_W-1:0]    r_retired;
  op_class_e           w_class;
  alu_ctrl_t           w_alu;
  logic                w_retire;
  logic                w_expired;
  logic                w_timer_clear;

  assign w_class       = op_class(32'(r_opcode));
  assign w_alu         = exec_alu(32'(r_opcode));
  assign w_timer_clear = (r_state != ST_MEM);
  assign o_dbg_state   = r_state;

  busy_timer #(.LIMIT(MEM_TIMEOUT), .W(16)) u_busy_timer (
    .clk       (CLK),
    .rst       (RESET),
    .i_clear   (w_timer_clear),
    .i_enable  (bus.busywait),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_opcode  <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && bus.instr_valid) r_opcode <= bus.opcode;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.instr_valid) w_next_state = ST_EXEC;
      ST_EXEC: begin
        case (w_class)
          CLS_LOADI, CLS_ALU:  w_next_state = ST_WB;
          CLS_LOAD, CLS_STORE: w_next_state = ST_MEM;
          CLS_JUMP, CLS_BEQ: begin
            w_next_state = ST_IDLE;
            w_retire     = 1'b1;
          end
          default:             w_next_state = ST_IDLE;
        endcase
      end
      ST_MEM: begin
        // Timeout wins over a late busywait release: the access is abandoned.
        if (w_expired) begin
          w_next_state = ST_IDLE;
        end else if (!bus.busywait) begin
          if (w_class == CLS_LOAD) begin
            w_next_state = ST_WB;
          end else begin
            w_next_state = ST_IDLE;
            w_retire     = 1'b1;
          end
        end
      end
      ST_WB: begin
        w_next_state = ST_IDLE;
        w_retire     = 1'b1;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.instr_ready    = 1'b0;
    bus.aluop          = '0;
    bus.aluSource      = 1'b0;
    bus.negate         = 1'b0;
    bus.regWriteEnable = 1'b0;
    bus.memRead        = 1'b0;
    bus.memWrite       = 1'b0;
    bus.pcWrite        = 1'b0;
    bus.branchTaken    = 1'b0;
    bus.jump           = 1'b0;
    bus.error          = 1'b0;
    bus.retired        = r_retired;
    case (r_state)
      ST_IDLE: bus.instr_ready = 1'b1;
      ST_EXEC: begin
        bus.aluop     = ALUOP_W'(w_alu.aluop);
        bus.aluSource = w_alu.alu_src;
        bus.negate    = w_alu.negate;
        case (w_class)
          CLS_JUMP: begin
            bus.pcWrite = 1'b1;
            bus.jump    = 1'b1;
          end
          CLS_BEQ: begin
            bus.pcWrite     = 1'b1;
            bus.branchTaken = bus.zero;
          end
          CLS_ILLEGAL: begin
            bus.pcWrite = 1'b1;
            bus.error   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        if (w_expired) begin
          bus.error = 1'b1;
        end else begin
          bus.memRead  = (w_class == CLS_LOAD);
          bus.memWrite = (w_class == CLS_STORE);
          bus.pcWrite  = (w_class == CLS_STORE) && !bus.busywait;
        end
      end
      ST_WB: begin
        bus.regWriteEnable = 1'b1;
        bus.pcWrite        = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
